branch_resolve_unit: RTL and testbench

//  Resolves conditional branches in EX and closes the loop back to the 2-bit branch_prediction table.

---
 rtl/branch_pkg.sv | 34 +++
 rtl/branch_compare.sv | 33 +++
 rtl/branch_resolve_unit.sv | 98 +++++++++
 tb/tb_branch_resolve_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for conditional-branch resolution and the
// 2-bit predictor update path.
package branch_pkg;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  // Must track the predictor table index width
  localparam int BP_TABLE_WIDTH = 3;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [12:0] imm;
    logic [2:0]  funct3;
    logic        pred;
  } ex_branch_t;

  typedef struct packed {
    logic                      attempt;
    logic                      taken;
    logic [BP_TABLE_WIDTH-1:0] slice;
  } bp_update_t;

  // 010/011 are not conditional-branch encodings
  function automatic logic is_cond_branch(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

endpackage

// File: rtl/branch_compare.sv
// Combinational branch condition evaluator: (funct3, rs1, rs2) -> taken.
// Kept standalone so the EX ALU can reuse it.
module branch_compare
  import branch_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  output logic        o_taken
);

  logic w_eq;
  logic w_lt;
  logic w_ltu;

  assign w_eq  = (i_rs1 == i_rs2);
  assign w_lt  = ($signed(i_rs1) < $signed(i_rs2));
  assign w_ltu = (i_rs1 < i_rs2);

  always_comb begin
    o_taken = 1'b0;
    case (i_funct3)
      BR_EQ:   o_taken = w_eq;
      BR_NE:   o_taken = ~w_eq;
      BR_LT:   o_taken = w_lt;
      BR_GE:   o_taken = ~w_lt;
      BR_LTU:  o_taken = w_ltu;
      BR_GEU:  o_taken = ~w_ltu;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: ID->EX register, mispredict flush/redirect,
// registered predictor update and saturating branch statistics.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int TABLE_WIDTH = 3,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ID_Valid,
  input  logic                   ID_IsBranch,
  input  logic [31:0]            ID_PC,
  input  logic [12:0]            ID_Imm,
  input  logic [2:0]             ID_Funct3,
  input  logic                   ID_PredictBranchTaken,
  input  logic                   Stall,
  input  logic [31:0]            EX_Rs1Data,
  input  logic [31:0]            EX_Rs2Data,
  output logic                   EX_Flush,
  output logic [31:0]            EX_RedirectPC,
  output logic                   Upd_AttemptBranch,
  output logic                   Upd_BranchTaken,
  output logic [TABLE_WIDTH-1:0] Upd_PC_Slice,
  output logic [CNT_WIDTH-1:0]   BranchCount,
  output logic [CNT_WIDTH-1:0]   MispredictCount
);

  ex_branch_t           r_ex;
  bp_update_t           r_upd;
  logic [CNT_WIDTH-1:0] r_branch_cnt;
  logic [CNT_WIDTH-1:0] r_mis_cnt;

  logic        w_taken;
  logic        w_resolve;
  logic        w_mispredict;
  logic [31:0] w_imm_sext;
  logic [31:0] w_target;
  logic [31:0] w_fallthru;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // ID -> EX: a flush kills the wrong-path ID instruction even under Stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex <= '0;
    end else if (EX_Flush) begin
      r_ex.valid <= 1'b0;
    end else if (!Stall) begin
      r_ex.valid  <= ID_Valid & ID_IsBranch;
      r_ex.pc     <= ID_PC;
      r_ex.imm    <= ID_Imm;
      r_ex.funct3 <= ID_Funct3;
      r_ex.pred   <= ID_PredictBranchTaken;
    end
  end

  branch_compare u_cmp (
    .i_funct3 (r_ex.funct3),
    .i_rs1    (EX_Rs1Data),
    .i_rs2    (EX_Rs2Data),
    .o_taken  (w_taken)
  );

  // EX resolution; a stalled branch resolves only once Stall drops
  assign w_resolve    = r_ex.valid & ~Stall & is_cond_branch(r_ex.funct3);
  assign w_mispredict = w_resolve & (w_taken != r_ex.pred);
  assign w_imm_sext   = {{19{r_ex.imm[12]}}, r_ex.imm};
  assign w_target     = r_ex.pc + w_imm_sext;
  assign w_fallthru   = r_ex.pc + 32'd4;

  assign EX_Flush      = w_mispredict;
  assign EX_RedirectPC = w_mispredict ? (w_taken ? w_target : w_fallthru) : 32'd0;

  // Predictor update and statistics, one edge after resolution
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_upd        <= '0;
      r_branch_cnt <= '0;
      r_mis_cnt    <= '0;
    end else begin
      r_upd.attempt <= w_resolve;
      r_upd.taken   <= w_resolve & w_taken;
      r_upd.slice   <= w_resolve ? r_ex.pc[TABLE_WIDTH+1:2] : '0;
      if (w_resolve)    r_branch_cnt <= sat_inc(r_branch_cnt);
      if (w_mispredict) r_mis_cnt    <= sat_inc(r_mis_cnt);
    end
  end

  assign Upd_AttemptBranch = r_upd.attempt;
  assign Upd_BranchTaken   = r_upd.taken;
  assign Upd_PC_Slice      = r_upd.slice;
  assign BranchCount       = r_branch_cnt;
  assign MispredictCount   = r_mis_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (4-bit counters so
// saturation is reachable quickly).
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ID_Valid, ID_IsBranch, ID_PredictBranchTaken, Stall;
  logic [31:0] ID_PC, EX_Rs1Data, EX_Rs2Data;
  logic [12:0] ID_Imm;
  logic [2:0]  ID_Funct3;
  logic        EX_Flush, Upd_AttemptBranch, Upd_BranchTaken;
  logic [31:0] EX_RedirectPC;
  logic [2:0]  Upd_PC_Slice;
  logic [3:0]  BranchCount, MispredictCount;

  int checks = 0;
  int errors = 0;

  branch_resolve_unit #(.TABLE_WIDTH(3), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .ID_Valid(ID_Valid), .ID_IsBranch(ID_IsBranch), .ID_PC(ID_PC), .ID_Imm(ID_Imm),
    .ID_Funct3(ID_Funct3), .ID_PredictBranchTaken(ID_PredictBranchTaken), .Stall(Stall),
    .EX_Rs1Data(EX_Rs1Data), .EX_Rs2Data(EX_Rs2Data),
    .EX_Flush(EX_Flush), .EX_RedirectPC(EX_RedirectPC),
    .Upd_AttemptBranch(Upd_AttemptBranch), .Upd_BranchTaken(Upd_BranchTaken),
    .Upd_PC_Slice(Upd_PC_Slice), .BranchCount(BranchCount), .MispredictCount(MispredictCount)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0; Stall = 1'b0; ID_Valid = 1'b0; ID_IsBranch = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  // Loads one branch into EX, then applies its operands; returns 2ns after the edge
  task automatic send(input logic [31:0] pc, input logic [12:0] imm, input logic [2:0] f3,
                      input logic pred, input logic [31:0] rs1, input logic [31:0] rs2);
    ID_Valid = 1'b1; ID_IsBranch = 1'b1; ID_PC = pc; ID_Imm = imm;
    ID_Funct3 = f3; ID_PredictBranchTaken = pred;
    @(posedge clk);
    #1;
    ID_Valid = 1'b0; ID_IsBranch = 1'b0; EX_Rs1Data = rs1; EX_Rs2Data = rs2;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; Stall = 1'b0; ID_Valid = 1'b0; ID_IsBranch = 1'b0; ID_PC = '0; ID_Imm = '0;
    ID_Funct3 = '0; ID_PredictBranchTaken = 1'b0; EX_Rs1Data = '0; EX_Rs2Data = '0;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (EX_Flush !== 1'b0) begin errors++; $display("FAIL rst_flush got %0d exp 0", EX_Flush); end
    checks++; if (EX_RedirectPC !== 32'd0) begin errors++; $display("FAIL rst_redirect got %0h exp 0", EX_RedirectPC); end
    checks++; if (Upd_AttemptBranch !== 1'b0) begin errors++; $display("FAIL rst_attempt got %0d exp 0", Upd_AttemptBranch); end
    checks++; if (BranchCount !== 4'd0) begin errors++; $display("FAIL rst_bcnt got %0d exp 0", BranchCount); end
    checks++; if (MispredictCount !== 4'd0) begin errors++; $display("FAIL rst_mcnt got %0d exp 0", MispredictCount); end
    rst = 1'b1;
  endtask

  task automatic test_beq();
    do_reset();
    send(32'h100, 13'd16, 3'b000, 1'b0, 32'd5, 32'd5);
    checks++; if (EX_Flush !== 1'b1) begin errors++; $display("FAIL beq_flush got %0d exp 1", EX_Flush); end
    checks++; if (EX_RedirectPC !== 32'h110) begin errors++; $display("FAIL beq_redirect got %0h exp 110", EX_RedirectPC); end
    tick();
    checks++; if (Upd_AttemptBranch !== 1'b1) begin errors++; $display("FAIL beq_attempt got %0d exp 1", Upd_AttemptBranch); end
    checks++; if (Upd_BranchTaken !== 1'b1) begin errors++; $display("FAIL beq_taken got %0d exp 1", Upd_BranchTaken); end
    checks++; if (Upd_PC_Slice !== 3'd0) begin errors++; $display("FAIL beq_slice got %0d exp 0", Upd_PC_Slice); end
    checks++; if (MispredictCount !== 4'd1) begin errors++; $display("FAIL beq_mcnt got %0d exp 1", MispredictCount); end
    checks++; if (BranchCount !== 4'd1) begin errors++; $display("FAIL beq_bcnt got %0d exp 1", BranchCount); end
    checks++; if (EX_Flush !== 1'b0) begin errors++; $display("FAIL beq_flush_after got %0d exp 0", EX_Flush); end
    tick();
    checks++; if (Upd_AttemptBranch !== 1'b0) begin errors++; $display("FAIL beq_attempt_once got %0d exp 0", Upd_AttemptBranch); end
  endtask

  task automatic test_blt();
    do_reset();
    send(32'h104, 13'd16, 3'b100, 1'b1, 32'hFFFF_FFFF, 32'd1);
    checks++; if (EX_Flush !== 1'b0) begin errors++; $display("FAIL blt_flush got %0d exp 0", EX_Flush); end
    checks++; if (EX_RedirectPC !== 32'd0) begin errors++; $display("FAIL blt_redirect got %0h exp 0", EX_RedirectPC); end
    tick();
    checks++; if (Upd_BranchTaken !== 1'b1) begin errors++; $display("FAIL blt_taken got %0d exp 1", Upd_BranchTaken); end
    checks++; if (Upd_PC_Slice !== 3'd1) begin errors++; $display("FAIL blt_slice got %0d exp 1", Upd_PC_Slice); end
    checks++; if (BranchCount !== 4'd1) begin errors++; $display("FAIL blt_bcnt got %0d exp 1", BranchCount); end
    checks++; if (MispredictCount !== 4'd0) begin errors++; $display("FAIL blt_mcnt got %0d exp 0", MispredictCount); end
  endtask

  task automatic test_redirect();
    do_reset();
    send(32'hFFFF_FFFC, 13'd8, 3'b001, 1'b0, 32'd1, 32'd2);
    checks++; if (EX_RedirectPC !== 32'h4) begin errors++; $display("FAIL bne_wrap got %0h exp 4", EX_RedirectPC); end
    tick();
    checks++; if (Upd_PC_Slice !== 3'd7) begin errors++; $display("FAIL bne_slice got %0d exp 7", Upd_PC_Slice); end
    send(32'h200, 13'h1FF8, 3'b101, 1'b0, 32'd3, 32'd3);
    checks++; if (EX_RedirectPC !== 32'h1F8) begin errors++; $display("FAIL bge_negimm got %0h exp 1f8", EX_RedirectPC); end
    tick();
    send(32'h200, 13'd16, 3'b111, 1'b1, 32'd1, 32'd2);
    checks++; if (EX_Flush !== 1'b1) begin errors++; $display("FAIL bgeu_flush got %0d exp 1", EX_Flush); end
    checks++; if (EX_RedirectPC !== 32'h204) begin errors++; $display("FAIL bgeu_fallthru got %0h exp 204", EX_RedirectPC); end
    tick();
    checks++; if (Upd_BranchTaken !== 1'b0) begin errors++; $display("FAIL bgeu_taken got %0d exp 0", Upd_BranchTaken); end
    send(32'h200, 13'd16, 3'b010, 1'b1, 32'd1, 32'd2);
    checks++; if (EX_Flush !== 1'b0) begin errors++; $display("FAIL f010_flush got %0d exp 0", EX_Flush); end
    tick();
    checks++; if (Upd_AttemptBranch !== 1'b0) begin errors++; $display("FAIL f010_attempt got %0d exp 0", Upd_AttemptBranch); end
    checks++; if (BranchCount !== 4'd3) begin errors++; $display("FAIL redir_bcnt got %0d exp 3", BranchCount); end
    checks++; if (MispredictCount !== 4'd3) begin errors++; $display("FAIL redir_mcnt got %0d exp 3", MispredictCount); end
  endtask

  task automatic test_stall();
    do_reset();
    send(32'h100, 13'd16, 3'b000, 1'b0, 32'd9, 32'd9);
    Stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (EX_Flush !== 1'b0) begin errors++; $display("FAIL stall_flush[%0d] got %0d exp 0", i, EX_Flush); end
      tick();
      checks++; if (Upd_AttemptBranch !== 1'b0) begin errors++; $display("FAIL stall_attempt[%0d] got %0d exp 0", i, Upd_AttemptBranch); end
      checks++; if (BranchCount !== 4'd0) begin errors++; $display("FAIL stall_bcnt[%0d] got %0d exp 0", i, BranchCount); end
    end
    Stall = 1'b0;
    #1;
    checks++; if (EX_Flush !== 1'b1) begin errors++; $display("FAIL stall_rel_flush got %0d exp 1", EX_Flush); end
    checks++; if (EX_RedirectPC !== 32'h110) begin errors++; $display("FAIL stall_rel_redirect got %0h exp 110", EX_RedirectPC); end
    tick();
    checks++; if (Upd_AttemptBranch !== 1'b1) begin errors++; $display("FAIL stall_rel_attempt got %0d exp 1", Upd_AttemptBranch); end
    checks++; if (EX_Flush !== 1'b0) begin errors++; $display("FAIL stall_rel_flush_once got %0d exp 0", EX_Flush); end
    checks++; if (BranchCount !== 4'd1) begin errors++; $display("FAIL stall_rel_bcnt got %0d exp 1", BranchCount); end
    checks++; if (MispredictCount !== 4'd1) begin errors++; $display("FAIL stall_rel_mcnt got %0d exp 1", MispredictCount); end
    tick();
    checks++; if (Upd_AttemptBranch !== 1'b0) begin errors++; $display("FAIL stall_no_dup got %0d exp 0", Upd_AttemptBranch); end
    checks++; if (BranchCount !== 4'd1) begin errors++; $display("FAIL stall_no_dup_bcnt got %0d exp 1", BranchCount); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(32'h200, 13'd8, 3'b000, 1'b1, 32'd7, 32'd7);
    send(32'h204, 13'd8, 3'b001, 1'b0, 32'd7, 32'd7);
    checks++; if (Upd_AttemptBranch !== 1'b1 || Upd_BranchTaken !== 1'b1 || Upd_PC_Slice !== 3'd0) begin
      errors++; $display("FAIL b2b_upd0 got %0d/%0d/%0d exp 1/1/0", Upd_AttemptBranch, Upd_BranchTaken, Upd_PC_Slice); end
    send(32'h208, 13'd8, 3'b110, 1'b1, 32'd1, 32'd2);
    checks++; if (Upd_AttemptBranch !== 1'b1 || Upd_BranchTaken !== 1'b0 || Upd_PC_Slice !== 3'd1) begin
      errors++; $display("FAIL b2b_upd1 got %0d/%0d/%0d exp 1/0/1", Upd_AttemptBranch, Upd_BranchTaken, Upd_PC_Slice); end
    checks++; if (EX_Flush !== 1'b0) begin errors++; $display("FAIL b2b_flush got %0d exp 0", EX_Flush); end
    tick();
    checks++; if (Upd_AttemptBranch !== 1'b1 || Upd_BranchTaken !== 1'b1 || Upd_PC_Slice !== 3'd2) begin
      errors++; $display("FAIL b2b_upd2 got %0d/%0d/%0d exp 1/1/2", Upd_AttemptBranch, Upd_BranchTaken, Upd_PC_Slice); end
    checks++; if (BranchCount !== 4'd3 || MispredictCount !== 4'd0) begin
      errors++; $display("FAIL b2b_cnt got %0d/%0d exp 3/0", BranchCount, MispredictCount); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    send(32'h300, 13'd8, 3'b000, 1'b1, 32'd4, 32'd4);
    send(32'h304, 13'd8, 3'b000, 1'b0, 32'd4, 32'd4);
    checks++; if (EX_Flush !== 1'b1 || Upd_AttemptBranch !== 1'b1) begin
      errors++; $display("FAIL mid_pre got %0d/%0d exp 1/1", EX_Flush, Upd_AttemptBranch); end
    rst = 1'b0;
    #1;
    checks++; if (EX_Flush !== 1'b0) begin errors++; $display("FAIL mid_flush got %0d exp 0", EX_Flush); end
    checks++; if (Upd_AttemptBranch !== 1'b0) begin errors++; $display("FAIL mid_attempt got %0d exp 0", Upd_AttemptBranch); end
    checks++; if (BranchCount !== 4'd0 || MispredictCount !== 4'd0) begin
      errors++; $display("FAIL mid_cnt got %0d/%0d exp 0/0", BranchCount, MispredictCount); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if (EX_Flush !== 1'b0 || Upd_AttemptBranch !== 1'b0 || BranchCount !== 4'd0) begin
      errors++; $display("FAIL mid_resume got %0d/%0d/%0d exp 0/0/0", EX_Flush, Upd_AttemptBranch, BranchCount); end
  endtask

  task automatic test_flush_kills_id();
    do_reset();
    send(32'h100, 13'd16, 3'b000, 1'b0, 32'd2, 32'd2);
    ID_Valid = 1'b1; ID_IsBranch = 1'b1; ID_PC = 32'h104; ID_Imm = 13'd16;
    ID_Funct3 = 3'b000; ID_PredictBranchTaken = 1'b0;
    #1;
    checks++; if (EX_Flush !== 1'b1) begin errors++; $display("FAIL fk_flush got %0d exp 1", EX_Flush); end
    tick();
    ID_Valid = 1'b0; ID_IsBranch = 1'b0;
    checks++; if (EX_Flush !== 1'b0) begin errors++; $display("FAIL fk_killed got %0d exp 0", EX_Flush); end
    tick();
    checks++; if (Upd_AttemptBranch !== 1'b0) begin errors++; $display("FAIL fk_attempt got %0d exp 0", Upd_AttemptBranch); end
    checks++; if (BranchCount !== 4'd1) begin errors++; $display("FAIL fk_bcnt got %0d exp 1", BranchCount); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send(32'h400, 13'd8, 3'b000, 1'b0, 32'd1, 32'd1);
      tick();
      if (i == 14) begin
        checks++; if (MispredictCount !== 4'hF) begin errors++; $display("FAIL sat_reach got %0d exp 15", MispredictCount); end
      end
    end
    checks++; if (MispredictCount !== 4'hF) begin errors++; $display("FAIL sat_mcnt got %0d exp 15", MispredictCount); end
    checks++; if (BranchCount !== 4'hF) begin errors++; $display("FAIL sat_bcnt got %0d exp 15", BranchCount); end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_blt();
    test_redirect();
    test_stall();
    test_back_to_back();
    test_reset_midrun();
    test_flush_kills_id();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
